// File: rtl/armv4_ctrl_pkg.sv
// ============================================================================
// Module      : armv4_ctrl_pkg
// Description : Shared state enum, mux-select encodings and Op class constants
//               for the multicycle ARMv4 control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package armv4_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] c_SRCB_REG  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_DATA   = 2'b01;
    localparam logic [1:0] c_RES_ALU    = 2'b10;

    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;
    localparam logic [1:0] c_OP_ILL = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/main_fsm_outputs.sv
// ============================================================================
// Module      : main_fsm_outputs
// Description : Combinational state-to-control decoder for the main FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_fsm_outputs
    import armv4_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic [1:0] i_op,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            FETCH: begin
                // Fetch strobes fire only in the cycle the memory completes
                o_ctrl.ir_write   = i_mem_ready;
                o_ctrl.next_pc    = i_mem_ready;
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = c_SRCB_FOUR;
                o_ctrl.result_src = c_RES_ALU;
            end
            DECODE: begin
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = c_SRCB_FOUR;
                o_ctrl.result_src = c_RES_ALU;
                o_ctrl.illegal    = (i_op == c_OP_ILL);
            end
            MEMADR: begin
                o_ctrl.alu_src_b  = c_SRCB_IMM;
            end
            MEMREAD: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = c_RES_ALUOUT;
            end
            MEMWB: begin
                o_ctrl.result_src = c_RES_DATA;
                o_ctrl.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                o_ctrl.adr_src    = 1'b1;
                o_ctrl.result_src = c_RES_ALUOUT;
                o_ctrl.mem_w      = 1'b1;
            end
            EXECUTER: begin
                o_ctrl.alu_src_b  = c_SRCB_REG;
                o_ctrl.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                o_ctrl.alu_src_b  = c_SRCB_IMM;
                o_ctrl.alu_op     = 1'b1;
            end
            ALUWB: begin
                o_ctrl.result_src = c_RES_ALUOUT;
                o_ctrl.reg_w      = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alu_src_b  = c_SRCB_IMM;
                o_ctrl.result_src = c_RES_ALU;
                o_ctrl.branch     = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
// ============================================================================
// Module      : multicycle_main_fsm
// Description : Main control FSM of a multicycle ARMv4 subset processor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_main_fsm
    import armv4_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    logic   w_unused_funct;

    // Only the I and L bits steer this FSM; the rest feed the ALU decoder
    assign w_unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:    w_next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    c_OP_DP:  w_next_state = Funct[5] ? EXECUTEI : EXECUTER;
                    c_OP_MEM: w_next_state = MEMADR;
                    c_OP_BR:  w_next_state = BRANCH;
                    default:  w_next_state = FETCH;
                endcase
            end
            MEMADR:   w_next_state = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next_state = MemReady ? MEMWB : MEMREAD;
            MEMWRITE: w_next_state = MemReady ? FETCH : MEMWRITE;
            EXECUTER: w_next_state = ALUWB;
            EXECUTEI: w_next_state = ALUWB;
            default:  w_next_state = FETCH;
        endcase
    end

    main_fsm_outputs u_outputs (
        .i_state     (r_state),
        .i_mem_ready (MemReady),
        .i_op        (Op),
        .o_ctrl      (w_ctrl)
    );

    assign IRWrite   = w_ctrl.ir_write;
    assign NextPC    = w_ctrl.next_pc;
    assign RegW      = w_ctrl.reg_w;
    assign MemW      = w_ctrl.mem_w;
    assign Branch    = w_ctrl.branch;
    assign AdrSrc    = w_ctrl.adr_src;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ResultSrc = w_ctrl.result_src;
    assign ALUOp     = w_ctrl.alu_op;
    assign Illegal   = w_ctrl.illegal;
    assign State     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
// ============================================================================
// Module      : tb_multicycle_main_fsm
// Description : Self-checking bench: directed scenarios plus random stimulus
//               against an instruction-plan reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_main_fsm;
    import armv4_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUOp, Illegal;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;
    logic [13:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;

    state_t plan[$];

    multicycle_main_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .Illegal   (Illegal),
        .State     (State)
    );

    assign w_obs = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
                    ALUSrcB, ResultSrc, ALUOp, Illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Control word per phase, packed as
    // {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,Illegal}
    function automatic logic [13:0] exp_ctrl(input state_t p, input logic mr, input logic [1:0] op);
        case (p)
            FETCH:    return {mr, mr, 3'b000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0};
            DECODE:   return {2'b00, 3'b000, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, (op == 2'b11)};
            MEMADR:   return {2'b00, 3'b000, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
            MEMREAD:  return {2'b00, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
            MEMWB:    return {2'b00, 3'b100, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
            MEMWRITE: return {2'b00, 3'b010, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
            EXECUTER: return {2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
            EXECUTEI: return {2'b00, 3'b000, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
            ALUWB:    return {2'b00, 3'b100, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
            BRANCH:   return {2'b00, 3'b001, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0};
            default:  return 14'd0;
        endcase
    endfunction

    function automatic state_t cur_phase();
        return (plan.size() == 0) ? FETCH : plan[0];
    endfunction

    // Empty plan means the machine is fetching; decode expands the
    // instruction's remaining phases, stall phases wait for MemReady.
    task automatic model_advance(input logic [1:0] op, input logic [5:0] f, input logic mr);
        state_t cur;
        cur = cur_phase();
        case (cur)
            FETCH: if (mr) plan.push_back(DECODE);
            DECODE: begin
                void'(plan.pop_front());
                case (op)
                    2'b00: begin
                        plan.push_back(f[5] ? EXECUTEI : EXECUTER);
                        plan.push_back(ALUWB);
                    end
                    2'b01: plan.push_back(MEMADR);
                    2'b10: plan.push_back(BRANCH);
                    default: ;
                endcase
            end
            MEMADR: begin
                void'(plan.pop_front());
                if (f[0]) begin
                    plan.push_back(MEMREAD);
                    plan.push_back(MEMWB);
                end else begin
                    plan.push_back(MEMWRITE);
                end
            end
            MEMREAD, MEMWRITE: if (mr) void'(plan.pop_front());
            default: void'(plan.pop_front());
        endcase
    endtask

    // Runs one instruction from FETCH back to the next fetch with MemReady held high
    task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] f,
                             input int exp_lat, input int exp_rw, input int exp_mw,
                             input int exp_br, input int exp_il);
        int n, rw, mw, br, il;
        n = 0; rw = 0; mw = 0; br = 0; il = 0;
        Op = op; Funct = f; MemReady = 1'b1;
        #1;
        do begin
            rw += int'(RegW); mw += int'(MemW); br += int'(Branch); il += int'(Illegal);
            @(posedge clk); #1;
            n++;
        end while (IRWrite !== 1'b1 && n < 20);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_regw"},    32'(rw), 32'(exp_rw));
        check({tag, "_memw"},    32'(mw), 32'(exp_mw));
        check({tag, "_branch"},  32'(br), 32'(exp_br));
        check({tag, "_illegal"}, 32'(il), 32'(exp_il));
    endtask

    initial begin
        int ir, np;
        state_t cur;
        rst = 1'b1; Op = 2'b00; Funct = 6'd0; MemReady = 1'b0;
        #1;
        check("reset_state", 32'(State), 32'(FETCH));
        check("reset_ctrl", 32'(w_obs), 32'(exp_ctrl(FETCH, 1'b0, 2'b00)));
        MemReady = 1'b1; #1;
        check("reset_ctrl_mr", 32'(w_obs), 32'(exp_ctrl(FETCH, 1'b1, 2'b00)));
        #11 rst = 1'b0;

        // Stalled fetch produces exactly one IRWrite/NextPC pulse
        MemReady = 1'b0; Op = 2'b11; ir = 0; np = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            ir += int'(IRWrite); np += int'(NextPC);
            @(posedge clk); #1;
        end
        MemReady = 1'b1; #1;
        ir += int'(IRWrite); np += int'(NextPC);
        @(posedge clk); #1;
        ir += int'(IRWrite); np += int'(NextPC);
        check("stall_irwrite_pulses", 32'(ir), 32'd1);
        check("stall_nextpc_pulses", 32'(np), 32'd1);
        check("stall_then_decode", 32'(State), 32'(DECODE));
        @(posedge clk); #1;
        check("illegal_back_to_fetch", 32'(State), 32'(FETCH));

        run_instr("dp_imm",  2'b00, 6'b101000, 4, 1, 0, 0, 0);
        run_instr("dp_reg",  2'b00, 6'b001000, 4, 1, 0, 0, 0);
        run_instr("load",    2'b01, 6'b011001, 5, 1, 0, 0, 0);
        run_instr("store",   2'b01, 6'b011000, 4, 0, 1, 0, 0);
        run_instr("branch",  2'b10, 6'b000000, 3, 0, 0, 1, 0);
        run_instr("illegal", 2'b11, 6'b111111, 2, 0, 0, 0, 1);

        // Asynchronous reset while a store is stalled
        Op = 2'b01; Funct = 6'b000000; MemReady = 1'b1;
        @(posedge clk); #1;
        MemReady = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("store_stall_state", 32'(State), 32'(MEMWRITE));
        check("store_stall_memw", 32'(MemW), 32'd1);
        @(posedge clk); #1;
        check("store_still_stalled", 32'(State), 32'(MEMWRITE));
        rst = 1'b1; #1;
        check("async_rst_state", 32'(State), 32'(FETCH));
        check("async_rst_memw", 32'(MemW), 32'd0);
        check("async_rst_regw", 32'(RegW), 32'd0);
        rst = 1'b0;

        // Random stimulus against the plan model
        @(posedge clk); #1;
        rst = 1'b1; #1; rst = 1'b0;
        plan.delete();
        for (int i = 0; i < 3000; i++) begin
            Op       = 2'($urandom_range(0, 3));
            Funct    = 6'($urandom);
            MemReady = ($urandom_range(0, 3) != 0);
            #2;
            cur = cur_phase();
            check("rand_state", 32'(State), 32'(cur));
            check("rand_ctrl", 32'(w_obs), 32'(exp_ctrl(cur, MemReady, Op)));
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1; #1;
                check("rand_rst_state", 32'(State), 32'(FETCH));
                check("rand_rst_ctrl", 32'(w_obs), 32'(exp_ctrl(FETCH, MemReady, Op)));
                plan.delete();
                rst = 1'b0;
            end
            @(posedge clk);
            model_advance(Op, Funct, MemReady);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
